cmos_pixel_packer: RTL and testbench
====================================

Name: cmos_pixel_packer

Overview:
- Capture stage directly upstream of the camera FIFO consumed by the Ethernet transmit path.
- Samples 8-bit CMOS pixels qualified by frame enable and line enable.
- Packs every 8 bytes into one 64-bit FIFO write word and produces cam_fifo_wren, cam_fifo_wrdata and a 16-bit frame mark.
- Pulses read_cam_fifo_trigger each time a burst of words is ready for the downstream packetiser.

Parameters:
- TRIG_WORDS, 128: number of words written within a frame between read_cam_fifo_trigger pulses (range 1..1023).
- PAD_BYTE, 8'h00: fill byte for a partial word flushed at line end.

Ports:
- cmos_pixclk  in  1: pixel clock; the only clock in the block.
- rst  in  1: asynchronous reset, active-low.
- cmos_data  in  8: pixel byte.
- cmos_fen  in  1: frame enable, high during a frame.
- cmos_len  in  1: line enable; a byte is valid when cmos_fen and cmos_len are both 1.
- cam_fifo_full  in  1: downstream FIFO full flag.
- cam_fifo_wren  out  1: FIFO write strobe, one cycle per word.
- cam_fifo_wrdata  out  64: packed word; first byte in [63:56], eighth byte in [7:0].
- FS_mark  out  16: frame sequence number of the current or most recent frame.
- rec_camdata_flag  out  1: high while a frame is being captured.
- read_cam_fifo_trigger  out  1: one-cycle pulse, burst ready.
- overflow_err  out  1: sticky flag, a word was dropped because the FIFO was full.

Behaviour:
Reset and registered edge detection
- While rst=0: all outputs are 0, byte counter is 0, word counter is 0, FSM is in SYNC.
- fen_d and len_d are registered copies of cmos_fen and cmos_len.
- frame_start = cmos_fen & ~fen_d.
- frame_end = ~cmos_fen & fen_d.
- line_end = ~cmos_len & len_d, evaluated only in ACTIVE.

FSM
- SYNC: entered after reset. Ignores all data until frame_start, which prevents capture of a partial frame.
  - If cmos_fen is already 1 when reset is released, the block waits for cmos_fen to go low and then high again.
  - frame_start moves the FSM to ACTIVE.
- ACTIVE: entered on frame_start. On entry:
  - FS_mark increments (16'hFFFF wraps to 16'h0000; the first frame after reset gets FS_mark=1).
  - rec_camdata_flag is set to 1.
  - overflow_err, the byte counter and the word counter are cleared.
  - If cmos_len is already 1 on the frame_start cycle, that byte is captured.
- FLUSH: entered on frame_end. Lasts exactly 1 cycle, then moves to SYNC.
  - Emits a pending padded word if the byte counter is nonzero.
  - Emits the final trigger if the word counter is nonzero.
  - Clears rec_camdata_flag.

Packing
- A 3-bit byte counter selects the byte lane.
- Valid bytes shift into a 64-bit shift register, MSB-first.
- When the 8th byte is captured in cycle N: cam_fifo_wrdata is updated and cam_fifo_wren=1 in cycle N+1. Latency is 1 cycle.
- cam_fifo_wrdata holds its value when cam_fifo_wren=0.
- At line_end with byte counter k≠0: the remaining 8-k low lanes are filled with PAD_BYTE, the word is written in the next cycle, and the byte counter resets to 0.
- Lines therefore never share a word.
- If line_end and frame_end occur in the same cycle: exactly one padded write is made, not two.

FIFO full
- If cam_fifo_full=1 in the cycle a write would occur: the write is suppressed (cam_fifo_wren stays 0), the word is discarded, and overflow_err is set.
- Packing continues without stalling, because the pixel stream cannot be back-pressured.
- Dropped words do not count toward the word counter.

Trigger
- The 10-bit word counter increments on each actual write.
- When it reaches TRIG_WORDS: read_cam_fifo_trigger pulses in the same cycle as that write, and the counter resets to 0.
- In FLUSH, if the counter is nonzero after any final write: one trigger pulse is issued and the counter is cleared.
- A frame therefore ends with at most one trailing trigger.

Reset mid-frame
- Asynchronous reset clears everything. The partial frame is abandoned, and the next capture requires a fresh frame_start (FS_mark restarts at 1).

Test Plan:
1. Reset with cmos_fen=0, then one frame of 2 lines × 16 bytes (0x00..0x0F per line), TRIG_WORDS=128 -> 4 writes; first word 64'h0001020304050607; FS_mark=1; one trigger in FLUSH; rec_camdata_flag high from frame_start until FLUSH.
2. Line of 10 bytes 0xA0..0xA9, PAD_BYTE=00 -> 2 writes: 64'hA0A1A2A3A4A5A6A7 and 64'hA8A9000000000000, the second one cycle after len falls.
3. TRIG_WORDS=4, one line of 40 bytes -> 5 writes; trigger pulses coincide with writes 4 and 8? No: with writes 4 only, the counter resets, and write 5 leaves counter=1, giving one trigger in FLUSH; total 2 pulses.
4. Release reset with cmos_fen=1 mid-frame -> no writes until fen falls and rises; the next frame has FS_mark=1.
5. cam_fifo_full=1 during the 2nd word of a 24-byte line -> only words 1 and 3 are written; overflow_err=1 and stays set until the next frame_start clears it.
6. Force FS_mark to 16'hFFFF via 65535 short frames (or force in sim), then one more frame -> FS_mark=0x0000; assert rst=0 mid-line -> all outputs are 0 within the same cycle.

Source files
------------

// File: rtl/cmos_pixel_packer_if.sv
// Camera-side pixel bus plus camera-FIFO write side of the pixel packer.
// The master drives pixels and the FIFO full flag. The slave is the packer.
interface cmos_pixel_packer_if;
    logic [7:0]  cmos_data;
    logic        cmos_fen;
    logic        cmos_len;
    logic        cam_fifo_full;
    logic        cam_fifo_wren;
    logic [63:0] cam_fifo_wrdata;
    logic [15:0] FS_mark;
    logic        rec_camdata_flag;
    logic        read_cam_fifo_trigger;
    logic        overflow_err;

    modport master (
        output cmos_data, cmos_fen, cmos_len, cam_fifo_full,
        input  cam_fifo_wren, cam_fifo_wrdata, FS_mark, rec_camdata_flag,
               read_cam_fifo_trigger, overflow_err
    );

    modport slave (
        input  cmos_data, cmos_fen, cmos_len, cam_fifo_full,
        output cam_fifo_wren, cam_fifo_wrdata, FS_mark, rec_camdata_flag,
               read_cam_fifo_trigger, overflow_err
    );
endinterface

// File: rtl/cmos_pixel_packer.sv
// Packs 8-bit CMOS pixels into 64-bit camera-FIFO words, MSB-first, one line per word group.
// Also tracks the frame sequence number and pulses a read trigger every TRIG_WORDS writes.
module cmos_pixel_packer #(
    parameter int unsigned TRIG_WORDS = 128,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic               cmos_pixclk,
    input  logic               rst,
    cmos_pixel_packer_if.slave bus
);

    localparam logic [9:0] TRIG_W = 10'(TRIG_WORDS);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        fen_d_q, len_d_q;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [63:0] sh_q, sh_d;
    logic [9:0]  wcnt_q, wcnt_d;
    logic        wren_q, wren_d;
    logic [63:0] wrdata_q, wrdata_d;
    logic [15:0] fs_q, fs_d;
    logic        rec_q, rec_d;
    logic        trig_q, trig_d;
    logic        ovf_q, ovf_d;

    logic        frame_start, frame_end, line_end, byte_vld;
    logic        capture, emit, fire;
    logic [63:0] sh_shift, pad_word, emit_word;
    logic [9:0]  wbase, wcnt_inc;

    always_comb begin
        frame_start = bus.cmos_fen & ~fen_d_q;
        frame_end   = ~bus.cmos_fen & fen_d_q;
        line_end    = (state_q == ACTIVE) & ~bus.cmos_len & len_d_q;
        byte_vld    = bus.cmos_fen & bus.cmos_len;
        sh_shift    = {sh_q[55:0], bus.cmos_data};

        // Left-justify the bcnt_q held bytes and fill the low lanes with PAD_BYTE.
        pad_word = sh_q;
        for (int j = 0; j < 8; j++) begin
            if (3'(j) >= bcnt_q) pad_word = {pad_word[55:0], PAD_BYTE};
        end

        state_d   = state_q;
        bcnt_d    = bcnt_q;
        sh_d      = sh_q;
        wbase     = wcnt_q;
        fs_d      = fs_q;
        rec_d     = rec_q;
        ovf_d     = ovf_q;
        capture   = 1'b0;
        emit      = 1'b0;
        emit_word = pad_word;

        case (state_q)
            SYNC: begin
                if (frame_start) begin
                    state_d = ACTIVE;
                    fs_d    = fs_q + 16'd1;
                    rec_d   = 1'b1;
                    ovf_d   = 1'b0;
                    bcnt_d  = 3'd0;
                    wbase   = 10'd0;
                    capture = bus.cmos_len;
                end
            end
            ACTIVE: begin
                // A coincident line end is left to FLUSH so only one padded word goes out.
                if (frame_end) begin
                    state_d = FLUSH;
                    rec_d   = 1'b0;
                end else if (line_end) begin
                    emit   = (bcnt_q != 3'd0);
                    bcnt_d = 3'd0;
                end else if (byte_vld) begin
                    capture   = 1'b1;
                    emit      = (bcnt_q == 3'd7);
                    emit_word = sh_shift;
                end
            end
            FLUSH: begin
                state_d = SYNC;
                emit    = (bcnt_q != 3'd0);
                bcnt_d  = 3'd0;
            end
            default: state_d = SYNC;
        endcase

        if (capture) begin
            sh_d   = sh_shift;
            bcnt_d = bcnt_d + 3'd1;
        end

        // The pixel stream cannot stall, so a word that meets a full FIFO is dropped.
        fire     = emit & ~bus.cam_fifo_full;
        if (emit & bus.cam_fifo_full) ovf_d = 1'b1;
        wren_d   = fire;
        wrdata_d = fire ? emit_word : wrdata_q;

        wcnt_inc = wbase + {9'd0, fire};
        wcnt_d   = wcnt_inc;
        trig_d   = 1'b0;
        if (fire && (wcnt_inc == TRIG_W)) begin
            trig_d = 1'b1;
            wcnt_d = 10'd0;
        end
        if ((state_q == FLUSH) && (wcnt_d != 10'd0)) begin
            trig_d = 1'b1;
            wcnt_d = 10'd0;
        end
    end

    // fen_d resets high so a frame already in progress at reset release is not captured.
    always_ff @(posedge cmos_pixclk or negedge rst) begin
        if (!rst) begin
            state_q  <= SYNC;
            fen_d_q  <= 1'b1;
            len_d_q  <= 1'b0;
            bcnt_q   <= 3'd0;
            sh_q     <= 64'd0;
            wcnt_q   <= 10'd0;
            wren_q   <= 1'b0;
            wrdata_q <= 64'd0;
            fs_q     <= 16'd0;
            rec_q    <= 1'b0;
            trig_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fen_d_q  <= bus.cmos_fen;
            len_d_q  <= bus.cmos_len;
            bcnt_q   <= bcnt_d;
            sh_q     <= sh_d;
            wcnt_q   <= wcnt_d;
            wren_q   <= wren_d;
            wrdata_q <= wrdata_d;
            fs_q     <= fs_d;
            rec_q    <= rec_d;
            trig_q   <= trig_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.cam_fifo_wren         = wren_q;
    assign bus.cam_fifo_wrdata       = wrdata_q;
    assign bus.FS_mark               = fs_q;
    assign bus.rec_camdata_flag      = rec_q;
    assign bus.read_cam_fifo_trigger = trig_q;
    assign bus.overflow_err          = ovf_q;

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Scoreboard bench for cmos_pixel_packer: one instance with TRIG_WORDS=128 and pad 00,
// one with TRIG_WORDS=4 and pad EE, both driven by the same pixel stream.
module tb_cmos_pixel_packer;

    localparam logic [7:0] PAD_B = 8'hEE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmos_pixel_packer_if ifa ();
    cmos_pixel_packer_if ifb ();

    cmos_pixel_packer #(.TRIG_WORDS(128), .PAD_BYTE(8'h00)) dut_a (
        .cmos_pixclk(clk), .rst(rst_n), .bus(ifa.slave));
    cmos_pixel_packer #(.TRIG_WORDS(4), .PAD_BYTE(PAD_B)) dut_b (
        .cmos_pixclk(clk), .rst(rst_n), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_a = 0, wr_b = 0, trig_a = 0, trig_b = 0, trig_b_w = 0;
    int last_wr_cyc = 0, len_fall_cyc = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] ea, eb;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every write strobe pops and compares one expected word.
    always @(negedge clk) begin
        if (ifa.cam_fifo_wren === 1'b1) begin
            wr_a++;
            last_wr_cyc = cyc;
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL wr_a_unexpected got %h want none", ifa.cam_fifo_wrdata);
            end else begin
                ea = qa.pop_front();
                if (ifa.cam_fifo_wrdata !== ea) begin
                    errors++;
                    $display("FAIL wr_a_data got %h want %h", ifa.cam_fifo_wrdata, ea);
                end
            end
        end
        if (ifb.cam_fifo_wren === 1'b1) begin
            wr_b++;
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL wr_b_unexpected got %h want none", ifb.cam_fifo_wrdata);
            end else begin
                eb = qb.pop_front();
                if (ifb.cam_fifo_wrdata !== eb) begin
                    errors++;
                    $display("FAIL wr_b_data got %h want %h", ifb.cam_fifo_wrdata, eb);
                end
            end
        end
        if (ifa.read_cam_fifo_trigger === 1'b1) trig_a++;
        if (ifb.read_cam_fifo_trigger === 1'b1) begin
            trig_b++;
            if (ifb.cam_fifo_wren === 1'b1) trig_b_w++;
        end
    end

    task automatic set_in(input logic fen, input logic len, input logic [7:0] d, input logic full);
        ifa.cmos_fen = fen; ifa.cmos_len = len; ifa.cmos_data = d; ifa.cam_fifo_full = full;
        ifb.cmos_fen = fen; ifb.cmos_len = len; ifb.cmos_data = d; ifb.cam_fifo_full = full;
    endtask

    task automatic step(input logic fen, input logic len, input logic [7:0] d, input logic full);
        @(posedge clk);
        #1;
        set_in(fen, len, d, full);
    endtask

    task automatic clr_counts();
        wr_a = 0; wr_b = 0; trig_a = 0; trig_b = 0; trig_b_w = 0;
    endtask

    function automatic logic [63:0] mk_word(input logic [7:0] base, input int first,
                                            input int cnt, input logic [7:0] pad);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++)
            w = {w[55:0], (i < cnt) ? 8'(int'(base) + first + i) : pad};
        return w;
    endfunction

    // Line of n bytes base, base+1, ...; word drop_w (if >= 0) meets a full FIFO.
    task automatic drive_line(input logic [7:0] base, input int n, input int drop_w);
        int nw;
        int cnt;
        nw = (n + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            cnt = n - 8 * w;
            if (cnt > 8) cnt = 8;
            if (w != drop_w) begin
                qa.push_back(mk_word(base, 8 * w, cnt, 8'h00));
                qb.push_back(mk_word(base, 8 * w, cnt, PAD_B));
            end
        end
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b1, 8'(int'(base) + i),
                 (drop_w >= 0) && (i >= 8 * drop_w) && (i <= 8 * drop_w + 8));
        step(1'b1, 1'b0, 8'h00, (drop_w >= 0) && (n <= 8 * drop_w + 8));
        len_fall_cyc = cyc;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic frame_begin();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic frame_finish();
        repeat (4) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ifa.cam_fifo_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got %b want 0", ifa.cam_fifo_wren); end
        checks++; if (ifa.cam_fifo_wrdata !== 64'd0) begin errors++; $display("FAIL rst_wrdata got %h want 0", ifa.cam_fifo_wrdata); end
        checks++; if (ifa.FS_mark !== 16'd0) begin errors++; $display("FAIL rst_fs got %h want 0", ifa.FS_mark); end
        checks++; if (ifa.rec_camdata_flag !== 1'b0) begin errors++; $display("FAIL rst_rec got %b want 0", ifa.rec_camdata_flag); end
        checks++; if (ifa.read_cam_fifo_trigger !== 1'b0) begin errors++; $display("FAIL rst_trig got %b want 0", ifa.read_cam_fifo_trigger); end
        checks++; if (ifa.overflow_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", ifa.overflow_err); end
        checks++; if (ifb.cam_fifo_wren !== 1'b0) begin errors++; $display("FAIL rst_wren_b got %b want 0", ifb.cam_fifo_wren); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_frame();
        clr_counts();
        frame_begin();
        @(negedge clk);
        checks++; if (ifa.rec_camdata_flag !== 1'b1) begin errors++; $display("FAIL frame_rec_on got %b want 1", ifa.rec_camdata_flag); end
        checks++; if (ifa.FS_mark !== 16'd1) begin errors++; $display("FAIL frame_fs got %h want 0001", ifa.FS_mark); end
        drive_line(8'h00, 16, -1);
        drive_line(8'h00, 16, -1);
        frame_finish();
        @(negedge clk);
        checks++; if (ifa.rec_camdata_flag !== 1'b0) begin errors++; $display("FAIL frame_rec_off got %b want 0", ifa.rec_camdata_flag); end
        checks++; if (wr_a != 4) begin errors++; $display("FAIL frame_writes got %0d want 4", wr_a); end
        checks++; if (trig_a != 1) begin errors++; $display("FAIL frame_trig got %0d want 1", trig_a); end
    endtask

    task automatic test_pad();
        clr_counts();
        frame_begin();
        drive_line(8'hA0, 10, -1);
        checks++; if (last_wr_cyc != len_fall_cyc + 1) begin errors++; $display("FAIL pad_latency got %0d want %0d", last_wr_cyc, len_fall_cyc + 1); end
        checks++; if (wr_a != 2) begin errors++; $display("FAIL pad_writes got %0d want 2", wr_a); end
        @(negedge clk);
        checks++; if (ifa.FS_mark !== 16'd2) begin errors++; $display("FAIL pad_fs got %h want 0002", ifa.FS_mark); end
        frame_finish();
    endtask

    task automatic test_trigger();
        clr_counts();
        frame_begin();
        drive_line(8'h40, 40, -1);
        frame_finish();
        @(negedge clk);
        checks++; if (wr_b != 5) begin errors++; $display("FAIL trig_writes_b got %0d want 5", wr_b); end
        checks++; if (trig_b != 2) begin errors++; $display("FAIL trig_pulses_b got %0d want 2", trig_b); end
        checks++; if (trig_b_w != 1) begin errors++; $display("FAIL trig_with_write_b got %0d want 1", trig_b_w); end
        checks++; if (trig_a != 1) begin errors++; $display("FAIL trig_pulses_a got %0d want 1", trig_a); end
    endtask

    task automatic test_fen_high_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (2) step(1'b1, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clr_counts();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'(i + 8'h30), 1'b0);
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checks++; if (wr_a != 0) begin errors++; $display("FAIL midframe_writes got %0d want 0", wr_a); end
        checks++; if (ifa.rec_camdata_flag !== 1'b0) begin errors++; $display("FAIL midframe_rec got %b want 0", ifa.rec_camdata_flag); end
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
        frame_begin();
        @(negedge clk);
        checks++; if (ifa.FS_mark !== 16'd1) begin errors++; $display("FAIL restart_fs got %h want 0001", ifa.FS_mark); end
        drive_line(8'h10, 8, -1);
        frame_finish();
        checks++; if (wr_a != 1) begin errors++; $display("FAIL restart_writes got %0d want 1", wr_a); end
    endtask

    task automatic test_overflow();
        clr_counts();
        frame_begin();
        drive_line(8'h80, 24, 1);
        @(negedge clk);
        checks++; if (ifa.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ifa.overflow_err); end
        frame_finish();
        @(negedge clk);
        checks++; if (ifa.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ifa.overflow_err); end
        checks++; if (wr_a != 2) begin errors++; $display("FAIL ovf_writes got %0d want 2", wr_a); end
        checks++; if (trig_a != 1) begin errors++; $display("FAIL ovf_trig got %0d want 1", trig_a); end
        frame_begin();
        @(negedge clk);
        checks++; if (ifa.overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ifa.overflow_err); end
        frame_finish();
    endtask

    task automatic test_wrap_and_reset();
        @(posedge clk);
        #1 force dut_a.fs_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut_a.fs_q;
        @(negedge clk);
        checks++; if (ifa.FS_mark !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset got %h want ffff", ifa.FS_mark); end
        frame_begin();
        @(negedge clk);
        checks++; if (ifa.FS_mark !== 16'h0000) begin errors++; $display("FAIL wrap_fs got %h want 0000", ifa.FS_mark); end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(i + 8'h55), 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (ifa.cam_fifo_wren !== 1'b0) begin errors++; $display("FAIL async_wren got %b want 0", ifa.cam_fifo_wren); end
        checks++; if (ifa.cam_fifo_wrdata !== 64'd0) begin errors++; $display("FAIL async_wrdata got %h want 0", ifa.cam_fifo_wrdata); end
        checks++; if (ifa.rec_camdata_flag !== 1'b0) begin errors++; $display("FAIL async_rec got %b want 0", ifa.rec_camdata_flag); end
        checks++; if (ifa.FS_mark !== 16'd0) begin errors++; $display("FAIL async_fs got %h want 0", ifa.FS_mark); end
        checks++; if (ifa.read_cam_fifo_trigger !== 1'b0 || ifa.overflow_err !== 1'b0) begin
            errors++; $display("FAIL async_trig_ovf got %b%b want 00", ifa.read_cam_fifo_trigger, ifa.overflow_err);
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        test_reset();
        test_frame();
        test_pad();
        test_trigger();
        test_fen_high_reset();
        test_overflow();
        test_wrap_and_reset();
        @(negedge clk);
        checks++; if (qa.size() != 0) begin errors++; $display("FAIL pending_a got %0d want 0", qa.size()); end
        checks++; if (qb.size() != 0) begin errors++; $display("FAIL pending_b got %0d want 0", qb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
